// File: rtl/bin2bcd_pkg.sv
// Shared types and sizing helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bin2bcd_state_t;

    // Smallest digit count whose decimal range covers every WIDTH-bit unsigned value.
    function automatic int bcd_digits(input int width);
        longint unsigned max_v;
        longint unsigned pow_v;
        int              d;
        max_v = (64'd1 << width) - 64'd1;
        pow_v = 64'd1;
        d     = 0;
        while (pow_v <= max_v) begin
            pow_v = pow_v * 64'd10;
            d     = d + 1;
        end
        if (d < 1) begin
            d = 1;
        end else begin
            d = d;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Per-digit double-dabble correction: digits of 5 or more get +3 before the shift.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    // Correct one digit, no carry out of the nibble.
    always_comb begin
        q = d;
        if (d >= 4'd5) begin
            q = d + 4'd3;
        end else begin
            q = d;
        end
    end

endmodule

// File: rtl/bin2bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle) with
// valid/ready on both sides and a leading-zero blanking mask.
module bin2bcd
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      x,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int ACC_W = 4 * DIGITS;

    if (DIGITS < bcd_digits(WIDTH)) begin : g_bad_digits
        $error("bin2bcd: DIGITS too small to hold 2**WIDTH-1");
    end

    bin2bcd_state_t     state_r;
    logic [WIDTH-1:0]   sr_r;
    logic [ACC_W-1:0]   acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [ACC_W-1:0]   bcd_r;
    logic [DIGITS-1:0]  blank_r;

    logic [ACC_W-1:0]   adj_s;
    logic [ACC_W-1:0]   next_acc_s;
    logic [DIGITS-1:0]  blank_s;
    logic               last_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3 u_add3 (
            .d (acc_r[4*g +: 4]),
            .q (adj_s[4*g +: 4])
        );
    end

    // Accumulator after this cycle's correct-then-shift, plus its blanking mask.
    always_comb begin
        next_acc_s = (adj_s << 1) | {{(ACC_W-1){1'b0}}, sr_r[WIDTH-1]};
        last_s     = (cnt_r == CNT_W'(WIDTH - 1));
        blank_s    = {DIGITS{1'b0}};
        for (int i = 1; i < DIGITS; i++) begin
            blank_s[i] = ~|(next_acc_s >> (4 * i));
        end
    end

    // Control FSM, shift datapath and output holding registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= IDLE;
            sr_r    <= {WIDTH{1'b0}};
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            bcd_r   <= {ACC_W{1'b0}};
            blank_r <= {DIGITS{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        sr_r    <= x;
                        acc_r   <= {ACC_W{1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= SHIFT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    acc_r <= next_acc_s;
                    sr_r  <= {sr_r[WIDTH-2:0], 1'b0};
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (last_s) begin
                        bcd_r   <= next_acc_s;
                        blank_r <= blank_s;
                        state_r <= DONE;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    // A simultaneous in_valid is deliberately ignored here.
                    if (out_ready) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign bcd       = bcd_r;
    assign blank     = blank_r;

endmodule

// File: tb/tb_bin2bcd.sv
// Directed self-checking bench for bin2bcd at the default 8-bit / 3-digit size.
module tb_bin2bcd;

    logic        clk;
    logic        nrst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  x;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] bcd;
    logic [2:0]  blank;

    int checks;
    int errors;
    int cyc;

    bin2bcd #(.WIDTH(8), .DIGITS(3)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .blank     (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Accept xv at the next edge, confirm 8-edge latency, optional isolation and hold.
    task automatic convert(input logic [7:0] xv, input logic [11:0] exp_bcd,
                           input logic [2:0] exp_blank, input bit isolate, input int hold);
        logic early_valid;
        logic ready_seen;
        early_valid = 1'b0;
        ready_seen  = 1'b0;
        @(negedge clk);
        check("in_ready_before_accept", in_ready, 1);
        x        = xv;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = isolate;
        for (int k = 0; k < 8; k++) begin
            if (isolate) x = 8'd99;
            early_valid = early_valid | out_valid;
            ready_seen  = ready_seen | in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("no_early_out_valid", early_valid, 0);
        check("in_ready_low_in_shift", ready_seen, 0);
        check("out_valid_at_latency", out_valid, 1);
        check("bcd_value", bcd, exp_bcd);
        check("blank_mask", blank, exp_blank);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_bcd", bcd, exp_bcd);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("out_valid_cleared", out_valid, 0);
        check("in_ready_after_consume", in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0]  bb_x   [3];
        logic [11:0] bb_bcd [3];
        int          last_cyc;
        bit          got;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        nrst      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = 8'd0;

        repeat (3) @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_bcd", bcd, 0);
        nrst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_in_ready", in_ready, 1);
            check("idle_out_valid", out_valid, 0);
        end

        convert(8'd128, 12'h128, 3'b000, 1'b0, 0);
        convert(8'd255, 12'h255, 3'b000, 1'b0, 0);
        convert(8'd0,   12'h000, 3'b110, 1'b0, 0);
        convert(8'd7,   12'h007, 3'b110, 1'b0, 0);
        convert(8'd42,  12'h042, 3'b100, 1'b0, 0);
        convert(8'd10,  12'h010, 3'b100, 1'b1, 0);
        convert(8'd200, 12'h200, 3'b000, 1'b0, 6);

        // Reset four cycles into a conversion of 99.
        @(negedge clk);
        x        = 8'd99;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_in_ready", in_ready, 1);
        check("midreset_bcd", bcd, 0);
        @(negedge clk);
        nrst = 1'b1;
        convert(8'd5, 12'h005, 3'b110, 1'b0, 0);

        // Back-to-back stream with out_ready tied high.
        bb_x[0] = 8'd11; bb_bcd[0] = 12'h011;
        bb_x[1] = 8'd3;  bb_bcd[1] = 12'h003;
        bb_x[2] = 8'd55; bb_bcd[2] = 12'h055;
        last_cyc  = 0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        x         = bb_x[0];
        for (int i = 0; i < 3; i++) begin
            got = 1'b0;
            for (int t = 0; t < 20 && !got; t++) begin
                @(negedge clk);
                got = out_valid;
            end
            check("b2b_result_arrived", got, 1);
            check("b2b_bcd", bcd, bb_bcd[i]);
            if (i > 0) check("b2b_spacing", cyc - last_cyc, 10);
            last_cyc = cyc;
            if (i < 2) x = bb_x[i+1];
            else in_valid = 1'b0;
        end
        out_ready = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
